// File: rtl/lcd_frame_streamer_pkg.sv
// Shared LCD package: frame FSM encoding, tile geometry and tile byte selection.
// Imported by the frame streamer and by the LCD controller side.
package lcd_frame_streamer_pkg;

  localparam int TILE_W    = 8;
  localparam int BYTE_W    = 8;
  localparam int TILE_BITS = TILE_W * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } frame_state_t;

  // Column sel of an 8x8 tile; tiling repeats every TILE_W columns.
  function automatic logic [BYTE_W-1:0] tile_byte(
    input logic [TILE_BITS-1:0] tile,
    input logic [2:0]           sel
  );
    logic [BYTE_W-1:0] b;
    case (sel)
      3'd0:    b = tile[7:0];
      3'd1:    b = tile[15:8];
      3'd2:    b = tile[23:16];
      3'd3:    b = tile[31:24];
      3'd4:    b = tile[39:32];
      3'd5:    b = tile[47:40];
      3'd6:    b = tile[55:48];
      3'd7:    b = tile[63:56];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_frame_streamer_page_col_counter.sv
// Page-major column/page position counter for the frame streamer.
// Advances once per accepted byte; last flags the final byte of the frame.
module lcd_page_col_counter
  import lcd_frame_streamer_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int PAGES  = 8,
  parameter int COL_W  = $clog2(COLS),
  parameter int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [PAGE_W-1:0] page,
  output logic              last
);

  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);

  assign last = (col == COL_MAX) && (page == PAGE_MAX);

  // Column wraps into the next page; page wraps at the end of the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col  <= '0;
      page <= '0;
    end else if (advance) begin
      if (col == COL_MAX) begin
        col <= '0;
        if (page == PAGE_MAX) begin
          page <= '0;
        end else begin
          page <= page + PAGE_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Streams an 8x8 tile pattern as page-major display bytes to the LCD controller,
// with automatic repeat and a pending tile that takes effect at frame boundaries.
module lcd_frame_streamer
  import lcd_frame_streamer_pkg::*;
#(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [TILE_BITS-1:0]  input_data,
  input  logic                  repeat_en,
  input  logic                  en_tran,
  output logic [BYTE_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int COL_W  = $clog2(COLS);
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;

  frame_state_t         state;
  logic [TILE_BITS-1:0] active_tile;
  logic [TILE_BITS-1:0] pending_tile;
  logic                 pending;
  logic                 accept;
  logic [COL_W-1:0]     col;
  logic [PAGE_W-1:0]    page;
  logic                 last;
  logic                 unused_pos;

  assign accept = (state == ST_STREAM) && data_valid && en_tran;

  lcd_page_col_counter #(
    .COLS   (COLS),
    .PAGES  (PAGES),
    .COL_W  (COL_W),
    .PAGE_W (PAGE_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept),
    .col     (col),
    .page    (page),
    .last    (last)
  );

  // Only the low column bits pick the tile byte; the rest of the position is informational.
  assign unused_pos = ^{page, col[COL_W-1:3]};

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      active_tile  <= '0;
      pending_tile <= '0;
      pending      <= 1'b0;
      data_out     <= 8'h00;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (load) begin
            active_tile <= input_data;
            data_out    <= tile_byte(input_data, 3'd0);
            data_valid  <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (load) begin
            pending_tile <= input_data;
            pending      <= 1'b1;
          end
          if (accept) begin
            if (last) begin
              data_valid <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              // Next column's low bits wrap naturally since COLS is a multiple of 8.
              data_out <= tile_byte(active_tile, col[2:0] + 3'd1);
            end
          end
        end

        ST_DONE: begin
          frame_done <= 1'b0;
          if (load) begin
            active_tile <= input_data;
            data_out    <= tile_byte(input_data, 3'd0);
            pending     <= 1'b0;
            data_valid  <= 1'b1;
            state       <= ST_STREAM;
          end else if (pending) begin
            active_tile <= pending_tile;
            data_out    <= tile_byte(pending_tile, 3'd0);
            pending     <= 1'b0;
            data_valid  <= 1'b1;
            state       <= ST_STREAM;
          end else if (repeat_en) begin
            data_out   <= tile_byte(active_tile, 3'd0);
            data_valid <= 1'b1;
            state      <= ST_STREAM;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state      <= ST_IDLE;
          data_valid <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          pending    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed self-checking bench for lcd_frame_streamer: full frames, stalls,
// pending tile at frame boundary, mid-frame reset and a small 16x1 instance.
module tb_lcd_frame_streamer;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [63:0] input_data;
  logic        repeat_en;
  logic        en_tran;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        frame_done;

  logic        s_rst_n;
  logic        s_load;
  logic [63:0] s_data;
  logic        s_rep;
  logic        s_en;
  logic [7:0]  s_dout;
  logic        s_valid;
  logic        s_busy;
  logic        s_done;

  int n_cmp;
  int n_mis;
  int r_acc;
  int r_cyc;
  bit r_done;

  logic [63:0] tile1;
  logic [63:0] tile2;
  logic [63:0] tile_ff;
  logic [63:0] s_tile_a;
  logic [63:0] s_tile_b;

  lcd_frame_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .input_data (input_data),
    .repeat_en  (repeat_en),
    .en_tran    (en_tran),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  lcd_frame_streamer #(.COLS(16), .PAGES(1)) dut_s (
    .clk        (clk),
    .rst_n      (s_rst_n),
    .load       (s_load),
    .input_data (s_data),
    .repeat_en  (s_rep),
    .en_tran    (s_en),
    .data_out   (s_dout),
    .data_valid (s_valid),
    .busy       (s_busy),
    .frame_done (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] d);
    input_data = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Called right after the edge that entered STREAM. ev_kind 1 = load ev_data at
  // acceptance ev_at, ev_kind 2 = reset at acceptance ev_at.
  task automatic run_frame(input logic [63:0] tile, input bit toggle, input int ev_at,
                           input int ev_kind, input logic [63:0] ev_data);
    int acc;
    int cyc;
    logic accept;
    acc = 0;
    cyc = 0;
    r_done = 1'b0;
    while (!r_done && cyc < 5000) begin
      cyc++;
      load = 1'b0;
      if (frame_done) begin
        r_done = 1'b1;
        check("done_valid", {63'd0, data_valid}, 64'd0);
        check("done_busy", {63'd0, busy}, 64'd1);
      end else begin
        check("valid", {63'd0, data_valid}, 64'd1);
        check("byte", {56'd0, data_out}, {56'd0, tile[8*(acc%8) +: 8]});
        en_tran = toggle ? cyc[0] : 1'b1;
        accept = data_valid && en_tran;
        if (accept && acc == ev_at && ev_kind == 1) begin
          load = 1'b1;
          input_data = ev_data;
        end
        if (accept && acc == ev_at && ev_kind == 2) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
          check("rst_valid", {63'd0, data_valid}, 64'd0);
          check("rst_busy", {63'd0, busy}, 64'd0);
          check("rst_dout", {56'd0, data_out}, 64'd0);
          check("rst_done", {63'd0, frame_done}, 64'd0);
          r_acc = acc;
          r_cyc = cyc;
          return;
        end
        if (accept) acc++;
        tick();
      end
    end
    r_acc = acc;
    r_cyc = cyc;
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_mis = 0;
    tile1    = 64'h8040201008040201;
    tile2    = 64'h0123456789ABCDEF;
    tile_ff  = 64'h00000000000000FF;
    s_tile_a = 64'h0807060504030201;
    s_tile_b = 64'h1122334455667788;

    // Reset with load asserted: load must be ignored.
    rst_n = 1'b0; load = 1'b1; input_data = tile1; repeat_en = 1'b0; en_tran = 1'b1;
    s_rst_n = 1'b0; s_load = 1'b0; s_data = 64'd0; s_rep = 1'b0; s_en = 1'b1;
    tick();
    tick();
    check("rst_valid0", {63'd0, data_valid}, 64'd0);
    check("rst_busy0", {63'd0, busy}, 64'd0);
    check("rst_dout0", {56'd0, data_out}, 64'd0);
    check("rst_done0", {63'd0, frame_done}, 64'd0);
    rst_n = 1'b1; s_rst_n = 1'b1; load = 1'b0;
    tick();
    check("idle_after_rst_busy", {63'd0, busy}, 64'd0);
    check("idle_after_rst_valid", {63'd0, data_valid}, 64'd0);

    // Full frame, en_tran held high.
    do_load(tile1);
    run_frame(tile1, 1'b0, -1, 0, 64'd0);
    check("t1_done_seen", {63'd0, r_done}, 64'd1);
    check("t1_acc", 64'(r_acc), 64'd1024);
    check("t1_done_cycle", 64'(r_cyc), 64'd1025);
    tick();
    check("t1_idle_busy", {63'd0, busy}, 64'd0);
    check("t1_idle_done", {63'd0, frame_done}, 64'd0);
    check("t1_idle_valid", {63'd0, data_valid}, 64'd0);

    // en_tran alternating 1,0: bytes held over stalls.
    do_load(tile2);
    run_frame(tile2, 1'b1, -1, 0, 64'd0);
    en_tran = 1'b1;
    check("t2_done_seen", {63'd0, r_done}, 64'd1);
    check("t2_acc", 64'(r_acc), 64'd1024);
    check("t2_done_cycle", 64'(r_cyc), 64'd2048);
    tick();
    check("t2_idle_busy", {63'd0, busy}, 64'd0);

    // Pending load mid-frame, applied at the next frame with repeat_en.
    repeat_en = 1'b1;
    do_load(tile1);
    run_frame(tile1, 1'b0, 500, 1, tile_ff);
    check("t3_done_seen", {63'd0, r_done}, 64'd1);
    check("t3_done_cycle", 64'(r_cyc), 64'd1025);
    repeat_en = 1'b0;
    tick();
    check("t3_f2_valid", {63'd0, data_valid}, 64'd1);
    check("t3_f2_byte0", {56'd0, data_out}, 64'hFF);
    check("t3_f2_busy", {63'd0, busy}, 64'd1);
    run_frame(tile_ff, 1'b0, -1, 0, 64'd0);
    check("t3_f2_done_cycle", 64'(r_cyc), 64'd1025);
    tick();
    check("t3_idle_busy", {63'd0, busy}, 64'd0);

    // Reset mid-frame at acceptance 300.
    do_load(tile2);
    run_frame(tile2, 1'b0, 300, 2, 64'd0);
    check("t4_rst_at", 64'(r_acc), 64'd300);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (data_valid || busy || frame_done) seen = 1'b1;
    end
    check("t4_quiet_after_rst", {63'd0, seen}, 64'd0);
    do_load(tile1);
    check("t4_reload_valid", {63'd0, data_valid}, 64'd1);
    check("t4_reload_byte0", {56'd0, data_out}, 64'h01);
    run_frame(tile1, 1'b0, -1, 0, 64'd0);
    check("t4_done_cycle", 64'(r_cyc), 64'd1025);
    tick();

    // 16x1 instance: load on last acceptance starts a second frame of the new tile.
    s_data = s_tile_a;
    s_load = 1'b1;
    tick();
    s_load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("s_valid_a", {63'd0, s_valid}, 64'd1);
      check("s_byte_a", {56'd0, s_dout}, {56'd0, s_tile_a[8*(i%8) +: 8]});
      if (i == 15) begin
        s_load = 1'b1;
        s_data = s_tile_b;
      end
      tick();
      s_load = 1'b0;
    end
    check("s_done_a", {63'd0, s_done}, 64'd1);
    check("s_done_valid_a", {63'd0, s_valid}, 64'd0);
    tick();
    check("s_done_pulse_a", {63'd0, s_done}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      check("s_valid_b", {63'd0, s_valid}, 64'd1);
      check("s_byte_b", {56'd0, s_dout}, {56'd0, s_tile_b[8*(i%8) +: 8]});
      tick();
    end
    check("s_done_b", {63'd0, s_done}, 64'd1);
    tick();
    check("s_idle_busy", {63'd0, s_busy}, 64'd0);
    check("s_idle_done", {63'd0, s_done}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
